// File: rtl/gold_nic_pkg.sv
// Shared constants for the gold_nic processor/router interface.
package gold_nic_pkg;

    // Packet and processor data width
    localparam int unsigned DATA_WIDTH = 64;

    // Virtual-channel bit position inside a packet
    localparam int unsigned VC_BIT = 63;

    // Processor register map
    localparam logic [1:0] ADDR_IBUF    = 2'b00;
    localparam logic [1:0] ADDR_IBUF_ST = 2'b01;
    localparam logic [1:0] ADDR_OBUF    = 2'b10;
    localparam logic [1:0] ADDR_OBUF_ST = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry channel buffer: one data register plus a full flag.
// Load takes priority over clear so a packet arriving on the same edge the
// processor drains the slot is never lost.
module nic_chan_buf #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // Capture data and track occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/gold_nic.sv
// Network interface controller between a processor core and the PE port of
// a ring router. One single-entry buffer per direction, polled via a 2-bit
// register map.
module gold_nic #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_polarity,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
);

    import gold_nic_pkg::*;

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_ibuf_load;
    logic                  w_ibuf_clr;
    logic                  w_ibuf_full;
    logic [DATA_WIDTH-1:0] w_ibuf_data;
    logic                  w_obuf_load;
    logic                  w_obuf_clr;
    logic                  w_obuf_full;
    logic [DATA_WIDTH-1:0] w_obuf_data;
    logic                  w_net_so;
    logic                  w_net_ri;
    logic [DATA_WIDTH-1:0] r_d_out;

    assign w_rd = nicEn & ~nicEnWr;
    assign w_wr = nicEn & nicEnWr;

    // Router side handshakes are purely combinational on buffer state
    assign w_net_ri = ~w_ibuf_full;
    assign w_net_so = w_obuf_full & net_ro & (w_obuf_data[VC_BIT] == net_polarity);

    // Reading the ibuf data register hands the slot back to the router
    assign w_ibuf_load = net_si & w_net_ri;
    assign w_ibuf_clr  = w_rd & (addr == ADDR_IBUF);

    // Writes to a full obuf are dropped, even if it drains on this edge
    assign w_obuf_load = w_wr & (addr == ADDR_OBUF) & ~w_obuf_full;
    assign w_obuf_clr  = w_net_so;

    nic_chan_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_ibuf (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_ibuf_load),
        .i_clr  (w_ibuf_clr),
        .i_data (net_di),
        .o_data (w_ibuf_data),
        .o_full (w_ibuf_full)
    );

    nic_chan_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_obuf_load),
        .i_clr  (w_obuf_clr),
        .i_data (d_in),
        .o_data (w_obuf_data),
        .o_full (w_obuf_full)
    );

    // Registered processor read port; status reflects pre-edge state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            case (addr)
                ADDR_IBUF:    r_d_out <= w_ibuf_data;
                ADDR_IBUF_ST: r_d_out <= {{(DATA_WIDTH-1){1'b0}}, w_ibuf_full};
                ADDR_OBUF_ST: r_d_out <= {{(DATA_WIDTH-1){1'b0}}, w_obuf_full};
                default:      r_d_out <= '0;
            endcase
        end
    end

    assign d_out  = r_d_out;
    assign net_so = w_net_so;
    assign net_ri = w_net_ri;
    assign net_do = w_obuf_data;

endmodule

// File: doc/gold_nic.md
Name: gold_nic

Overview:
- Network interface controller between one processor core and the PE port of one ring router node.
- Processor side: a register-mapped, 2-bit-address load/store interface.
- Network side: drives the router's PE-input handshake (pesi/pedi, honouring peri) and consumes the router's PE-output handshake (peso/pedo, driving pero).
- Holds one single-entry buffer per direction, with status registers the processor polls.

Parameters:
- DATA_WIDTH, 64: packet/data width. Bit 63 of a packet is the virtual-channel (VC) bit.
- ADDR_WIDTH, 2: processor register address width. Fixed at 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  register select: 00 input-buffer data, 01 input-buffer status, 10 output-buffer data, 11 output-buffer status.
- d_in  in  64  processor write data.
- d_out  out  64  processor read data, registered.
- nicEn  in  1  processor access enable.
- nicEnWr  in  1  1 = write, 0 = read (qualified by nicEn).
- net_polarity  in  1  ring polarity from the router.
- net_so  out  1  packet valid to router (router pesi).
- net_ro  in  1  router ready to accept (router peri).
- net_do  out  64  packet to router (router pedi).
- net_si  in  1  packet valid from router (router peso).
- net_ri  out  1  NIC ready to accept (router pero).
- net_di  in  64  packet from router (router pedo).

Behaviour:
- Reset: ibuf_full=0, obuf_full=0, ibuf=0, obuf=0, d_out=0, net_so=0, net_ri=1, net_do=0.
- Input channel (router to NIC):
  - net_ri = ~ibuf_full, combinational.
  - When net_si & net_ri: ibuf<=net_di and ibuf_full<=1 at the edge.
- Output channel (NIC to router):
  - net_do = obuf, combinational.
  - net_so = obuf_full & net_ro & (obuf[63] == net_polarity), combinational.
  - When net_so is high: obuf_full<=0 at the edge. The router latches net_do on that same edge.
- Processor read (nicEn & ~nicEnWr), one-cycle latency; d_out loaded at the edge with:
  - addr 00: ibuf; also ibuf_full<=0 on the same edge.
  - addr 01: {63'b0, ibuf_full}.
  - addr 11: {63'b0, obuf_full}.
  - addr 10: 64'b0.
- No read: d_out holds its previous value.
- Processor write (nicEn & nicEnWr):
  - addr 10 with obuf_full=0: obuf<=d_in, obuf_full<=1.
  - addr 10 with obuf_full=1: write silently dropped, buffer unchanged. This applies even if net_so drains obuf in the same cycle.
  - Any other addr: ignored.
- Simultaneous events:
  - Read of addr 00 while ibuf is full: the router cannot deliver in that cycle because net_ri=0. Full clears; net_ri rises the next cycle.
  - Router delivery and status read (addr 01) in the same cycle: d_out reports the pre-edge status (0).
  - Status registers always reflect the state before the edge.
- Reset asserted mid-transfer: both buffers are emptied and any pending packet is lost. net_so and net_ri reach their reset values in the cycle after the reset edge.
- No packet-field decoding beyond bit 63. The data payload passes through unmodified.

Decomposition:
- Shared package gold_nic_pkg:
  - address constants ADDR_IBUF=2'b00, ADDR_IBUF_ST=2'b01, ADDR_OBUF=2'b10, ADDR_OBUF_ST=2'b11;
  - VC_BIT=63;
  - DATA_WIDTH.
- One sub-module, nic_chan_buf: a single-entry register plus full flag, with load/clear strobes. It is instantiated twice, once for ibuf and once for obuf.

Test Plan:
- Reset, then read addr 01 and addr 11 -> d_out=0 both, net_ri=1, net_so=0.
- Write addr 10 with d_in=64'h8000_0000_0000_00A5, net_ro=1:
  - net_polarity=0 -> net_so=0, read of addr 11 returns 1.
  - net_polarity then toggles to 1 -> net_so=1 for exactly one cycle, net_do=64'h8000_0000_0000_00A5, then addr 11 reads 0.
- Write addr 10 twice back-to-back with net_ro=0 (values 64'h1 then 64'h2) -> obuf keeps 64'h1, the second write is dropped, addr 11 reads 1.
- Router drives net_si=1 with net_di=64'h0000_1234_5678_9ABC -> net_ri falls next cycle:
  - addr 01 reads 1;
  - read addr 00 -> d_out=64'h0000_1234_5678_9ABC one cycle later;
  - net_ri=1 the cycle after that.
- With ibuf full, hold net_si=1 carrying a second packet 64'hDEAD -> not accepted until the addr 00 read. It is accepted the cycle after net_ri rises, and a subsequent read returns 64'hDEAD.
- Assert reset while obuf_full=1 and ibuf_full=1 -> both status registers read 0 after reset, net_so=0, net_ri=1, d_out=0.
